// File: rtl/dct_block_feeder_if.sv
// Upstream pixel stream into the DCT block feeder.
// A beat transfers when in_valid and in_ready are both high.
interface dct_block_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/dct_block_feeder.sv
// Ping-pong buffers raster 8x8 blocks and streams each one to the dct core
// as a single 128-cycle burst in folded-butterfly column order.
module dct_block_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dct_block_feeder_if.slave     up,
    output logic [DATA_WIDTH-1:0] x,
    output logic                  sumDiffSel,
    output logic                  load,
    output logic                  x_valid,
    output logic                  block_start
);
    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    localparam logic [3:0] GAP_LAST =
        (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] mem [0:127];
    logic [1:0]            full, full_nx;
    logic                  wbank, rbank;
    logic [5:0]            wcnt;
    logic [6:0]            seq;
    logic [3:0]            gcnt;
    logic                  rel_pend, rel_bank;
    logic                  fire, issue, last;
    logic [2:0]            row, k, col;
    logic                  phase;
    logic [6:0]            raddr;

    // seq = {row, phase, k}; it wraps to zero after the last sample
    assign row   = seq[6:4];
    assign phase = seq[3];
    assign k     = seq[2:0];
    assign col   = k[0] ? (3'd7 - {1'b0, k[2:1]}) : {1'b0, k[2:1]};
    assign raddr = {rbank, row, col};

    assign up.in_ready = ~full[wbank];
    assign fire        = up.in_valid & up.in_ready;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE:    issue = full[rbank];
            STREAM:  issue = 1'b1;
            GAP:     if (gcnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        last = issue & (&seq);
        if (issue) begin
            if (!last)               state_nx = STREAM;
            else if (GAP_CYCLES > 0) state_nx = GAP;
            else                     state_nx = IDLE;
        end
    end

    // release lands one edge after the last read so in_ready follows last x
    always_comb begin
        full_nx = full;
        if (rel_pend) full_nx[rel_bank] = 1'b0;
        if (fire && wcnt == 6'd63) full_nx[wbank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (fire) mem[{wbank, wcnt}] <= up.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            wcnt     <= 6'd0;
            seq      <= 7'd0;
            gcnt     <= 4'd0;
            rel_pend <= 1'b0;
            rel_bank <= 1'b0;
        end else begin
            full     <= full_nx;
            rel_pend <= last;
            if (last) begin
                rel_bank <= rbank;
                rbank    <= ~rbank;
            end
            if (fire) begin
                wcnt <= wcnt + 6'd1;
                if (wcnt == 6'd63) wbank <= ~wbank;
            end
            if (issue) seq <= seq + 7'd1;
            if (state == GAP) gcnt <= gcnt + 4'd1;
            else              gcnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= '0;
            sumDiffSel  <= 1'b0;
            load        <= 1'b0;
            x_valid     <= 1'b0;
            block_start <= 1'b0;
        end else begin
            x           <= issue ? mem[raddr] : '0;
            sumDiffSel  <= issue & phase;
            load        <= issue & (k == 3'd0);
            x_valid     <= issue;
            block_start <= issue & (seq == 7'd0);
        end
    end
endmodule
